// File: rtl/mm_inst_scheduler_if.sv
// mm_inst_scheduler_if: dispatcher, mm engine and status signals of the instruction scheduler
interface mm_inst_scheduler_if #(
  parameter int MM_INST_BIT_WIDTH = 128,
  parameter int CNT_WIDTH = 16
);
  logic inst_valid;
  logic inst_ready;
  logic [MM_INST_BIT_WIDTH-1:0] inst_data;
  logic [MM_INST_BIT_WIDTH-1:0] mm_ctrl_instruction;
  logic mm_ap_start;
  logic mm_ap_done;
  logic cmpl_valid;
  logic cmpl_ready;
  logic err_illegal;
  logic err_spurious_done;
  logic busy;
  logic [CNT_WIDTH-1:0] issued_count;
  logic [CNT_WIDTH-1:0] error_count;
  modport master (
    output inst_valid, inst_data, mm_ap_done, cmpl_ready,
    input inst_ready, mm_ctrl_instruction, mm_ap_start, cmpl_valid,
    input err_illegal, err_spurious_done, busy, issued_count, error_count
  );
  modport slave (
    input inst_valid, inst_data, mm_ap_done, cmpl_ready,
    output inst_ready, mm_ctrl_instruction, mm_ap_start, cmpl_valid,
    output err_illegal, err_spurious_done, busy, issued_count, error_count
  );
endinterface

// File: rtl/mm_inst_scheduler.sv
// mm_inst_scheduler: queues MM instructions and runs them one at a time on the mm engine
module mm_inst_scheduler #(
  parameter int MM_INST_BIT_WIDTH = 128,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH = 16
) (
  input logic kernel_clk,
  input logic kernel_rst,
  mm_inst_scheduler_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, WAIT_DONE = 2'd2, CMPL = 2'd3;
  logic [1:0] state, next_state;
  logic [MM_INST_BIT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [MM_INST_BIT_WIDTH-1:0] head, inst_reg;
  logic [AW:0] wr_ptr, rd_ptr;
  logic empty, full, push, pop, legal;
  logic err_illegal_q, spurious_q;
  logic [CNT_WIDTH-1:0] issued_q, error_q;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push = bus.inst_valid && !full;
  assign pop = state == IDLE && !empty;
  assign head = mem[rd_ptr[AW-1:0]];
  // one input source, one output buffer, and non-zero N, Ci, Co
  assign legal = $onehot(head[4:1]) && $onehot(head[10:9]) && |head[127:112] && |head[95:88] && |head[87:80];
  always_comb begin
    next_state = state == IDLE      ? (pop && legal ? START : IDLE) :
                 state == START     ? WAIT_DONE :
                 state == WAIT_DONE ? (bus.mm_ap_done ? CMPL : WAIT_DONE) :
                                      (bus.cmpl_ready ? IDLE : CMPL);
  end
  always_ff @(posedge kernel_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.inst_data;
  end
  always_ff @(posedge kernel_clk) begin
    if (kernel_rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      inst_reg <= '0;
      err_illegal_q <= 1'b0;
      spurious_q <= 1'b0;
      issued_q <= '0;
      error_q <= '0;
    end else begin
      state <= next_state;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (pop && legal) inst_reg <= head;
      err_illegal_q <= pop && !legal;
      if (pop && !legal) error_q <= error_q + CNT_WIDTH'(1);
      if (state == START) issued_q <= issued_q + CNT_WIDTH'(1);
      if (bus.mm_ap_done && state != WAIT_DONE) spurious_q <= 1'b1;
    end
  end
  assign bus.inst_ready = !full;
  assign bus.mm_ctrl_instruction = inst_reg;
  assign bus.mm_ap_start = state == START;
  assign bus.cmpl_valid = state == CMPL;
  assign bus.err_illegal = err_illegal_q;
  assign bus.err_spurious_done = spurious_q;
  assign bus.busy = state != IDLE || !empty;
  assign bus.issued_count = issued_q;
  assign bus.error_count = error_q;
endmodule

// File: tb/tb_mm_inst_scheduler.sv
// tb_mm_inst_scheduler: scoreboard and vector-table bench for mm_inst_scheduler
module tb_mm_inst_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic auto_en = 1'b1;
  logic auto_done = 1'b0;
  logic inj_done = 1'b0;
  int done_delay = 3;
  int dcnt = 0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int starts = 0;
  int cmpls = 0;
  int ill = 0;
  int last_start_edge = 0;
  int last_done_edge = 0;
  int push_edge = 0;
  bit outstanding = 1'b0;
  logic [127:0] exp_q[$];
  typedef struct {
    string name;
    logic [127:0] d;
    bit ok;
  } vec_t;
  vec_t tv[10];

  mm_inst_scheduler_if #(.MM_INST_BIT_WIDTH(128), .CNT_WIDTH(16)) bus();
  mm_inst_scheduler #(.MM_INST_BIT_WIDTH(128), .FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
    .kernel_clk(clk),
    .kernel_rst(rst),
    .bus(bus)
  );
  assign bus.mm_ap_done = auto_done | inj_done;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic bit legal_m(input logic [127:0] d);
    return $countones(d[4:1]) == 1 && $countones(d[10:9]) == 1 &&
           d[127:112] != 16'd0 && d[95:88] != 8'd0 && d[87:80] != 8'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [127:0] d);
    int n = 0;
    bus.inst_valid = 1'b1;
    bus.inst_data = d;
    while (!bus.inst_ready && n < 300) begin
      tick();
      n++;
    end
    if (bus.inst_ready) begin
      tick();
      push_edge = cyc;
      if (legal_m(d)) exp_q.push_back(d);
    end else begin
      total++;
      bad++;
      $display("FAIL push_ready_timeout: got inst_ready=0 expected 1 within 300 cycles");
    end
    bus.inst_valid = 1'b0;
  endtask

  task automatic wait_idle(input string n, input int budget);
    for (int i = 0; i < budget && bus.busy; i++) tick();
    chk(n, bus.busy, 1'b0);
  endtask

  // mm model: answers each ap_start with a single ap_done after done_delay cycles
  always @(posedge clk) begin
    auto_done <= 1'b0;
    if (rst) dcnt <= 0;
    else if (bus.mm_ap_start && auto_en) dcnt <= done_delay;
    else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) auto_done <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) outstanding = 1'b0;
    else begin
      if (bus.mm_ap_start) begin
        chk("start_one_at_a_time", {127'd0, outstanding}, 128'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL start_unexpected: got ap_start with inst %0h expected none", bus.mm_ctrl_instruction);
        end else chk("start_inst", bus.mm_ctrl_instruction, exp_q.pop_front());
        outstanding = 1'b1;
        starts++;
        last_start_edge = cyc + 1;
      end
      if (bus.mm_ap_done) last_done_edge = cyc + 1;
      if (bus.cmpl_valid && bus.cmpl_ready) begin
        outstanding = 1'b0;
        cmpls++;
      end
      if (bus.err_illegal) ill++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1);
  end

  initial begin
    logic [127:0] a, b, c;
    int s0, e0, i0, c0, h, nill;
    tv[0] = '{"legal_in1_out9",  128'h0001_0000_0404_0000_0000_0000_0000_0202, 1'b1};
    tv[1] = '{"in_bits1_2",      128'h0001_0000_0404_0000_0000_0000_0000_0206, 1'b0};
    tv[2] = '{"no_out_bit",      128'h0001_0000_0404_0000_0000_0000_0000_0002, 1'b0};
    tv[3] = '{"n_zero",          128'h0000_0000_0404_0000_0000_0000_0000_0202, 1'b0};
    tv[4] = '{"legal_in4_out10", 128'h0100_0000_0101_0000_0000_0000_0000_0410, 1'b1};
    tv[5] = '{"ci_zero",         128'h0001_0000_0004_0000_0000_0000_0000_0202, 1'b0};
    tv[6] = '{"co_zero",         128'h0001_0000_0400_0000_0000_0000_0000_0202, 1'b0};
    tv[7] = '{"out_both",        128'h0001_0000_0404_0000_0000_0000_0000_0602, 1'b0};
    tv[8] = '{"no_in_bit",       128'h0001_0000_0404_0000_0000_0000_0000_0200, 1'b0};
    tv[9] = '{"ci_co_in_111_96", 128'h0001_0404_0000_0000_0000_0000_0000_0202, 1'b0};
    bus.inst_valid = 1'b0;
    bus.inst_data = '0;
    bus.cmpl_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_ctrl", bus.mm_ctrl_instruction, 128'd0);
    chk("rst_flags", {bus.mm_ap_start, bus.cmpl_valid, bus.err_illegal, bus.err_spurious_done, bus.busy}, 128'd0);
    chk("rst_counts", {bus.issued_count, bus.error_count}, 128'd0);
    chk("rst_ready", bus.inst_ready, 1'b1);

    // single legal instruction: start and completion latency
    a = tv[0].d;
    done_delay = 10;
    push(a);
    for (int i = 0; i < 10 && starts < 1; i++) tick();
    chk("t1_start_latency", last_start_edge - push_edge, 2);
    chk("t1_ctrl", bus.mm_ctrl_instruction, a);
    for (int i = 0; i < 40 && !bus.cmpl_valid; i++) tick();
    chk("t1_cmpl_valid", bus.cmpl_valid, 1'b1);
    chk("t1_cmpl_latency", cyc, last_done_edge);
    chk("t1_issued", bus.issued_count, 1);
    tick();
    chk("t1_cmpl_drop", bus.cmpl_valid, 1'b0);
    chk("t1_idle", bus.busy, 1'b0);

    // five back-to-back pushes fill the queue behind one running instruction
    s0 = starts;
    done_delay = 50;
    for (int i = 0; i < 5; i++) push({16'(i + 2), 16'h0, 16'h0808, 64'h0, 16'h0204});
    chk("t2_ready_full", bus.inst_ready, 1'b0);
    chk("t2_busy", bus.busy, 1'b1);
    wait_idle("t2_drain", 600);
    chk("t2_starts", starts - s0, 5);
    chk("t2_issued", bus.issued_count, 6);
    chk("t2_sb_empty", exp_q.size(), 0);

    // legality vectors
    done_delay = 3;
    nill = 0;
    for (int k = 0; k < 10; k++) begin
      e0 = bus.error_count;
      s0 = starts;
      i0 = ill;
      push(tv[k].d);
      wait_idle({"t3_idle_", tv[k].name}, 40);
      tick();
      chk({"t3_errcnt_", tv[k].name}, bus.error_count - e0, {127'd0, !tv[k].ok});
      chk({"t3_start_", tv[k].name}, starts - s0, {127'd0, tv[k].ok});
      chk({"t3_pulse_", tv[k].name}, ill - i0, {127'd0, !tv[k].ok});
      if (!tv[k].ok) nill++;
    end
    chk("t3_error_total", bus.error_count, nill);

    // completion back-pressure with a second instruction queued
    a = {16'h0003, 16'h0, 16'h0202, 64'h0, 16'h0208};
    b = {16'h0004, 16'h0, 16'h0303, 64'h0, 16'h0410};
    bus.cmpl_ready = 1'b0;
    done_delay = 5;
    s0 = starts;
    push(a);
    push(b);
    for (int i = 0; i < 40 && !bus.cmpl_valid; i++) tick();
    chk("t4_cmpl_valid", bus.cmpl_valid, 1'b1);
    h = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!bus.cmpl_valid || bus.mm_ctrl_instruction !== a || starts != s0 + 1) h = 0;
    end
    chk("t4_hold_stable", h, 1);
    bus.cmpl_ready = 1'b1;
    tick();
    h = cyc;
    for (int i = 0; i < 10 && starts < s0 + 2; i++) tick();
    chk("t4_next_start_gap", last_start_edge - h, 2);
    wait_idle("t4_drain", 40);
    chk("t4_no_spurious", bus.err_spurious_done, 1'b0);

    // spurious ap_done in IDLE and in START
    auto_en = 1'b0;
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    tick();
    chk("t5_spurious_idle", bus.err_spurious_done, 1'b1);
    c = {16'h0005, 16'h0, 16'h0101, 64'h0, 16'h0202};
    c0 = cmpls;
    push(c);
    for (int i = 0; i < 10 && !bus.mm_ap_start; i++) tick();
    chk("t5_in_start", bus.mm_ap_start, 1'b1);
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    repeat (5) tick();
    chk("t5_still_waiting", {bus.cmpl_valid, bus.busy}, 2'b01);
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    chk("t5_real_done", bus.cmpl_valid, 1'b1);
    wait_idle("t5_drain", 10);
    chk("t5_cmpls", cmpls - c0, 1);

    // reset while waiting for ap_done with three queued
    for (int i = 0; i < 4; i++) push({16'(i + 7), 16'h0, 16'h0202, 64'h0, 16'h0202});
    repeat (3) tick();
    chk("t6_pre_busy", {bus.busy, bus.inst_ready, bus.cmpl_valid}, 3'b110);
    rst = 1'b1;
    tick();
    chk("t6_rst_outs", {bus.mm_ctrl_instruction, bus.mm_ap_start, bus.cmpl_valid, bus.err_illegal,
                        bus.err_spurious_done, bus.busy, bus.issued_count, bus.error_count}, '0);
    chk("t6_rst_ready", bus.inst_ready, 1'b1);
    rst = 1'b0;
    exp_q.delete();
    auto_en = 1'b1;
    done_delay = 4;
    s0 = starts;
    push(tv[4].d);
    wait_idle("t6_post_run", 40);
    chk("t6_issued", bus.issued_count, 1);
    chk("t6_starts", starts - s0, 1);
    chk("t6_sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
